// File: rtl/instr_mem_loader.sv
// instr_mem_loader: assembles a big-endian byte stream into 32-bit words,
// writes them to consecutive word-aligned RAM addresses and holds the CPU
// while a program is loading. Loading ends on HALT_WORD or when RAM is full.
module instr_mem_loader #(
    parameter int unsigned           NB_BITS   = 32,
    parameter int unsigned           RAM_DEPTH = 12,
    parameter logic [NB_BITS-1:0]    HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_valid,
    output logic [NB_BITS-1:0]   o_mem_data,
    output logic [RAM_DEPTH-1:0] o_mem_addr,
    output logic                 o_mem_we,
    output logic                 o_cpu_hold,
    output logic                 o_done,
    output logic                 o_halt_seen,
    output logic                 o_overflow,
    output logic [RAM_DEPTH-2:0] o_word_count
);

    localparam int unsigned            CAP_WORDS = 2 ** (RAM_DEPTH - 2);
    localparam logic [RAM_DEPTH-2:0]   CAP       = (RAM_DEPTH-1)'(CAP_WORDS);
    localparam logic [RAM_DEPTH-2:0]   CNT_ONE   = (RAM_DEPTH-1)'(1);
    localparam logic [RAM_DEPTH-1:0]   ADDR_STEP = RAM_DEPTH'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q;
    logic [1:0]           byte_idx_q;
    logic [NB_BITS-1:0]   asm_q;
    logic [RAM_DEPTH-1:0] next_addr_q;
    logic [NB_BITS-1:0]   mem_data_q;
    logic [RAM_DEPTH-1:0] mem_addr_q;
    logic                 mem_we_q;
    logic                 cpu_hold_q;
    logic                 done_q;
    logic                 halt_seen_q;
    logic                 overflow_q;
    logic [RAM_DEPTH-2:0] word_count_q;
    logic [RAM_DEPTH-2:0] count_inc;

    assign count_inc = word_count_q + CNT_ONE;

    // Loader FSM with all outputs registered; i_start restarts from any state
    // (the pending write in WRITE has already been presented this cycle).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            next_addr_q  <= '0;
            mem_data_q   <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            halt_seen_q  <= 1'b0;
            overflow_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (i_start) begin
                state_q      <= LOAD;
                byte_idx_q   <= '0;
                next_addr_q  <= '0;
                word_count_q <= '0;
                cpu_hold_q   <= 1'b1;
                done_q       <= 1'b0;
                halt_seen_q  <= 1'b0;
                overflow_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: ;
                    LOAD: begin
                        if (i_rx_valid) begin
                            asm_q      <= {asm_q[NB_BITS-9:0], i_rx_data};
                            byte_idx_q <= byte_idx_q + 2'd1;
                            if (byte_idx_q == 2'd3) begin
                                mem_data_q <= {asm_q[NB_BITS-9:0], i_rx_data};
                                mem_addr_q <= next_addr_q;
                                mem_we_q   <= 1'b1;
                                state_q    <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        next_addr_q  <= next_addr_q + ADDR_STEP;
                        word_count_q <= count_inc;
                        if (mem_data_q == HALT_WORD) begin
                            state_q     <= DONE;
                            halt_seen_q <= 1'b1;
                            done_q      <= 1'b1;
                            cpu_hold_q  <= 1'b0;
                        end else if (count_inc == CAP) begin
                            // RAM is now full: a byte here has nowhere to go.
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                            if (i_rx_valid) begin
                                overflow_q <= 1'b1;
                            end
                        end else begin
                            state_q <= LOAD;
                            if (i_rx_valid) begin
                                asm_q      <= {asm_q[NB_BITS-9:0], i_rx_data};
                                byte_idx_q <= 2'd1;
                            end
                        end
                    end
                    DONE: begin
                        if (i_rx_valid && !halt_seen_q) begin
                            overflow_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_mem_data   = mem_data_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_we     = mem_we_q;
    assign o_cpu_hold   = cpu_hold_q;
    assign o_done       = done_q;
    assign o_halt_seen  = halt_seen_q;
    assign o_overflow   = overflow_q;
    assign o_word_count = word_count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a default-size instance and a
// RAM_DEPTH=4 instance (4-word capacity) share the same stimulus.
module tb_instr_mem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic [31:0] m_data;
    logic [11:0] m_addr;
    logic        m_we, m_hold, m_done, m_halt, m_ovf;
    logic [10:0] m_cnt;

    logic [31:0] s_data;
    logic [3:0]  s_addr;
    logic        s_we, s_hold, s_done, s_halt, s_ovf;
    logic [2:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_wd[$];
    logic [11:0] m_wa[$];
    logic [31:0] s_wd[$];
    logic [3:0]  s_wa[$];

    instr_mem_loader dut_main (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_mem_data(m_data), .o_mem_addr(m_addr), .o_mem_we(m_we),
        .o_cpu_hold(m_hold), .o_done(m_done), .o_halt_seen(m_halt),
        .o_overflow(m_ovf), .o_word_count(m_cnt)
    );

    instr_mem_loader #(.RAM_DEPTH(4)) dut_small (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_mem_data(s_data), .o_mem_addr(s_addr), .o_mem_we(s_we),
        .o_cpu_hold(s_hold), .o_done(s_done), .o_halt_seen(s_halt),
        .o_overflow(s_ovf), .o_word_count(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write logger, sampled mid-cycle when outputs are stable.
    always @(negedge clk) begin
        if (m_we) begin m_wd.push_back(m_data); m_wa.push_back(m_addr); end
        if (s_we) begin s_wd.push_back(s_data); s_wa.push_back(s_addr); end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic clear_logs();
        m_wd.delete(); m_wa.delete(); s_wd.delete(); s_wa.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({m_we, m_hold, m_done, m_halt, m_ovf} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected %b", {m_we, m_hold, m_done, m_halt, m_ovf}, 5'b0);
        end
        checks++;
        if (m_data !== 32'h0 || m_addr !== 12'h0 || m_cnt !== 11'd0) begin
            errors++; $display("FAIL reset_regs: got %h/%h/%0d expected 0/0/0", m_data, m_addr, m_cnt);
        end
    endtask

    task automatic test_single_word();
        clear_logs();
        pulse_start();
        send_byte(8'h8C); send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
        checks++;
        if (m_we !== 1'b1 || m_addr !== 12'h000 || m_data !== 32'h8C01_0004) begin
            errors++; $display("FAIL single_write: got we=%b addr=%h data=%h expected we=1 addr=000 data=8c010004", m_we, m_addr, m_data);
        end
        idle(1);
        checks++;
        if (m_we !== 1'b0 || m_cnt !== 11'd1 || m_hold !== 1'b1) begin
            errors++; $display("FAIL single_after: got we=%b cnt=%0d hold=%b expected we=0 cnt=1 hold=1", m_we, m_cnt, m_hold);
        end
    endtask

    task automatic test_halt();
        logic [31:0] exp_d [4] = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hFFFF_FFFF};
        do_reset();
        clear_logs();
        pulse_start();
        for (int i = 0; i < 4; i++) send_word(exp_d[i]);
        checks++;
        if (m_we !== 1'b1 || m_done !== 1'b0 || m_hold !== 1'b1) begin
            errors++; $display("FAIL halt_wcycle: got we=%b done=%b hold=%b expected we=1 done=0 hold=1", m_we, m_done, m_hold);
        end
        idle(1);
        checks++;
        if (m_done !== 1'b1 || m_halt !== 1'b1 || m_hold !== 1'b0 || m_cnt !== 11'd4) begin
            errors++; $display("FAIL halt_end: got done=%b halt=%b hold=%b cnt=%0d expected 1 1 0 4", m_done, m_halt, m_hold, m_cnt);
        end
        checks++;
        if (m_wd.size() != 4) begin
            errors++; $display("FAIL halt_nwrites: got %0d expected 4", m_wd.size());
        end
        for (int i = 0; i < 4 && i < m_wd.size(); i++) begin
            checks++;
            if (m_wd[i] !== exp_d[i] || m_wa[i] !== 12'(i * 4)) begin
                errors++; $display("FAIL halt_write%0d: got %h@%h expected %h@%h", i, m_wd[i], m_wa[i], exp_d[i], 12'(i * 4));
            end
        end
        send_byte(8'h12);
        idle(1);
        checks++;
        if (m_ovf !== 1'b0 || m_wd.size() != 4) begin
            errors++; $display("FAIL halt_ignore: got ovf=%b writes=%0d expected ovf=0 writes=4", m_ovf, m_wd.size());
        end
    endtask

    task automatic test_capacity();
        logic [31:0] exp_d [4] = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10};
        do_reset();
        clear_logs();
        pulse_start();
        for (int i = 0; i < 4; i++) send_word(exp_d[i]);
        idle(1);
        checks++;
        if (s_done !== 1'b1 || s_halt !== 1'b0 || s_ovf !== 1'b0 || s_hold !== 1'b0 || s_cnt !== 3'd4) begin
            errors++; $display("FAIL cap_end: got done=%b halt=%b ovf=%b hold=%b cnt=%0d expected 1 0 0 0 4", s_done, s_halt, s_ovf, s_hold, s_cnt);
        end
        for (int i = 0; i < 4 && i < s_wd.size(); i++) begin
            checks++;
            if (s_wd[i] !== exp_d[i] || s_wa[i] !== 4'(i * 4)) begin
                errors++; $display("FAIL cap_write%0d: got %h@%h expected %h@%h", i, s_wd[i], s_wa[i], exp_d[i], 4'(i * 4));
            end
        end
        idle(1);
        send_byte(8'hEE);
        idle(2);
        checks++;
        if (s_ovf !== 1'b1 || s_wd.size() != 4 || s_done !== 1'b1) begin
            errors++; $display("FAIL cap_overflow: got ovf=%b writes=%0d done=%b expected ovf=1 writes=4 done=1", s_ovf, s_wd.size(), s_done);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_logs();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
        idle(2);
        checks++;
        if (m_wd.size() != 2 || m_cnt !== 11'd2 || m_hold !== 1'b1) begin
            errors++; $display("FAIL b2b_count: got writes=%0d cnt=%0d hold=%b expected 2 2 1", m_wd.size(), m_cnt, m_hold);
        end
        if (m_wd.size() == 2) begin
            checks++;
            if (m_wd[0] !== 32'hA0A1_A2A3 || m_wa[0] !== 12'h000 || m_wd[1] !== 32'hA4A5_A6A7 || m_wa[1] !== 12'h004) begin
                errors++; $display("FAIL b2b_data: got %h@%h %h@%h expected a0a1a2a3@000 a4a5a6a7@004", m_wd[0], m_wa[0], m_wd[1], m_wa[1]);
            end
        end
    endtask

    task automatic test_restart();
        do_reset();
        clear_logs();
        pulse_start();
        send_byte(8'h55); send_byte(8'h66);
        pulse_start();
        send_word(32'h0000_0020);
        idle(2);
        checks++;
        if (m_wd.size() != 1 || m_cnt !== 11'd1) begin
            errors++; $display("FAIL restart_count: got writes=%0d cnt=%0d expected 1 1", m_wd.size(), m_cnt);
        end else begin
            checks++;
            if (m_wd[0] !== 32'h0000_0020 || m_wa[0] !== 12'h000) begin
                errors++; $display("FAIL restart_data: got %h@%h expected 00000020@000", m_wd[0], m_wa[0]);
            end
        end
        // Start coincident with a byte: the byte must be dropped.
        clear_logs();
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
        @(negedge clk);
        start = 1'b0; rx_valid = 1'b0;
        send_word(32'h0000_0030);
        idle(2);
        checks++;
        if (m_wd.size() != 1) begin
            errors++; $display("FAIL start_byte_count: got writes=%0d expected 1", m_wd.size());
        end else begin
            checks++;
            if (m_wd[0] !== 32'h0000_0030 || m_wa[0] !== 12'h000) begin
                errors++; $display("FAIL start_byte_data: got %h@%h expected 00000030@000", m_wd[0], m_wa[0]);
            end
        end
    endtask

    task automatic test_rst_midload();
        clear_logs();
        pulse_start();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        rst = 1'b1; rx_data = 8'h04; rx_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; rx_valid = 1'b0;
        checks++;
        if ({m_we, m_hold, m_done, m_halt, m_ovf} !== 5'b0 || m_data !== 32'h0 || m_addr !== 12'h0 || m_cnt !== 11'd0) begin
            errors++; $display("FAIL rst_outputs: got flags=%b data=%h addr=%h cnt=%0d expected all 0", {m_we, m_hold, m_done, m_halt, m_ovf}, m_data, m_addr, m_cnt);
        end
        send_word(32'hDEAD_BEEF);
        idle(2);
        checks++;
        if (m_wd.size() != 0 || m_hold !== 1'b0 || m_cnt !== 11'd0) begin
            errors++; $display("FAIL rst_ignore: got writes=%0d hold=%b cnt=%0d expected 0 0 0", m_wd.size(), m_hold, m_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        idle(2);
        test_reset();
        test_single_word();
        test_halt();
        test_capacity();
        test_back_to_back();
        test_restart();
        test_rst_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
